h75_panel_receiver: RTL
=======================

Name: h75_panel_receiver

Overview:
Sink-side model of a HUB75 panel, used for loopback diagnostics on the CAPE. It samples the panel-side signals from the HUB75 timing generator: led_clk, latch_enable, oe, ABCDE and the six RGB data lines. For each row it shifts the pixel data into a capture RAM write port, tracks rows and frames, and checks protocol conformance. It also measures each OE on-time, so the software can read back the BCM plane timing and the frame contents.

Parameters:
SYNC_STAGES, 2, synchronizer depth on every panel input (all inputs share the same depth, so they stay aligned)
NUM_ROWS, 32, number of scanned rows per frame
MAX_COLS, 512, capture columns per row (must equal 2^9)
OE_CNT_W, 20, width of the OE on-time counter

Ports:
clk  in  1  system clock; must be at least 4x the led_clk frequency
reset  in  1  synchronous, active-high reset
pixels_per_row  in  10  expected columns per row
clear_err  in  1  one-cycle pulse that clears status_err
led_clk  in  1  panel shift clock; data is taken on its rising edge
latch_enable  in  1  active-high row latch
oe  in  1  active-low output enable
ABCDE  in  5  row address
rgb  in  6  {b1,g1,r1,b0,g0,r0}
wr_en  out  1  capture RAM write strobe
wr_addr  out  14  {rx_row[4:0], col[8:0]}
wr_data  out  6  sampled rgb
row_latched  out  1  one-cycle pulse on each latch
latched_row  out  5  ABCDE value captured at the latch
col_count  out  10  columns shifted before the latch
frame_done  out  1  one-cycle pulse when the latch of row NUM_ROWS-1 is accepted
oe_valid  out  1  one-cycle pulse at the end of each OE pulse
oe_row  out  5  latched_row value that was valid while OE was active
oe_cycles  out  OE_CNT_W  clk cycles for which OE was active (saturating)
status_err  out  3  sticky error flags: {oe_overlap, row_error, col_error}

Behaviour:
- Reset:
  - All outputs are 0.
  - The column counter, rx_row and the OE counter are 0.
  - Synchronizer flops are set to the idle levels: led_clk=0, latch_enable=0, oe=1.
  - Reset asserted in the middle of a row discards that row; no partial writes occur afterwards.
- Front end:
  - All inputs pass through SYNC_STAGES flops.
  - Edge detect compares the last synchronizer stage with one extra flop.
- Shift engine (states S_IDLE, S_SHIFT):
  - On a led_clk rising edge, wr_en=1 for one cycle, with wr_addr={rx_row,col} and wr_data=the synchronized rgb.
  - Write latency: edge at the input pin to wr_en is SYNC_STAGES+1 clk.
  - col then increments, and the state goes S_IDLE->S_SHIFT on the first edge of a row.
  - If col==MAX_COLS-1 has already been written, further edges are not written; col saturates at MAX_COLS and col_error is set.
- Latch (rising edge of latch_enable, from either state, back to S_IDLE):
  - The outputs take col_count=col, latched_row=ABCDE, and row_latched=1 for one cycle.
  - col_error is set if col!=pixels_per_row.
  - row_error is set if ABCDE!=rx_row.
  - col is cleared to 0.
  - rx_row increments; if rx_row==NUM_ROWS-1 it wraps to 0 and frame_done=1 in the same cycle as row_latched.
- Simultaneous led_clk and latch edges in one cycle: the shift is processed first and is included in col_count; the new row starts with col=0.
- OE meter (states M_OFF, M_ON). Shifting may continue while OE is active.
  - oe falling edge: M_ON, counter=1.
  - While in M_ON: the counter increments every clk and saturates at all-ones.
  - oe rising edge: oe_valid=1 for one cycle, oe_cycles=counter, oe_row=latched_row; state returns to M_OFF.
  - A latch edge while in M_ON sets oe_overlap, and the latch is still processed.
- status_err:
  - Bits are sticky; clear_err zeroes them.
  - If a new error and clear_err occur in the same cycle, the set wins.
- Both rx_row and col are purely counter-derived. ABCDE is only checked, never used for addressing.

Optional Feature:
H75_RX_OE_STATS_EN
- Defined: the OE meter is built as described above.
- Undefined: the meter is removed; oe_valid, oe_row and oe_cycles are tied to 0, and oe_overlap is never set. The shift engine, latch handling and the other error bits are unchanged.

Decomposition:
- Package h75_pkg holds:
  - NUM_ROWS
  - the column and row widths (9 and 5)
  - the RGB bit index constants
  - the status_err bit indices (COL_ERR=0, ROW_ERR=1, OE_OVL=2)
  - the state encodings for the shift engine and the OE meter
- Sub-module h75_rx_sync: a parameterized SYNC_STAGES synchronizer with rise/fall pulse outputs, instantiated once per control input.

Test Plan:
1. Reset asserted for 3 clk with idle inputs -> all outputs are 0; the first led_clk edge after reset writes wr_addr=0x0000.
2. pixels_per_row=64, 64 led_clk edges with rgb=col[5:0], ABCDE=0, then a latch -> 64 writes at addresses 0..63 with matching data; row_latched=1, col_count=64, status_err=0.
3. 63 edges, then a latch with ABCDE=5 (rx_row=0) -> col_count=63 and status_err=3'b011; clear_err -> 3'b000.
4. oe held low for 2100 clk after the row-2 latch -> oe_valid=1 with oe_cycles=2100 and oe_row=2.
5. 32 rows of 64 columns with ABCDE=0..31 -> frame_done on the 32nd latch only; the next row writes from address 0x0000 and status_err stays 0.
6. A latch edge while oe is low -> status_err[2]=1. A latch and a led_clk edge in the same cycle -> that column is included in col_count.

Source files
------------

// File: rtl/h75_pkg.sv
// Shared constants for the HUB75 panel receiver: geometry, RGB bit
// positions, status bit indices and FSM encodings.
package h75_pkg;

  localparam int unsigned NUM_ROWS = 32;
  localparam int unsigned COL_W    = 9;
  localparam int unsigned ROW_W    = 5;

  // Bit positions within rgb = {b1,g1,r1,b0,g0,r0}
  localparam int unsigned RGB_R0 = 0;
  localparam int unsigned RGB_G0 = 1;
  localparam int unsigned RGB_B0 = 2;
  localparam int unsigned RGB_R1 = 3;
  localparam int unsigned RGB_G1 = 4;
  localparam int unsigned RGB_B1 = 5;

  // status_err bit indices
  localparam int unsigned COL_ERR = 0;
  localparam int unsigned ROW_ERR = 1;
  localparam int unsigned OE_OVL  = 2;

  // Shift engine states
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  // OE meter states
  localparam logic [0:0] M_OFF = 1'b0;
  localparam logic [0:0] M_ON  = 1'b1;

endpackage

// File: rtl/h75_rx_sync.sv
// Single-bit input synchronizer with rise/fall pulse outputs. Reset loads
// every flop with the signal's idle level so no edge is seen on release.
module h75_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE        = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {SYNC_STAGES{IDLE}};
      r_prev <= IDLE;
    end else begin
      r_sync[0] <= i_d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/h75_panel_receiver.sv
// HUB75 panel-side receiver for loopback diagnostics: captures shifted
// pixels into a RAM write port, tracks rows/frames, flags protocol errors
// and (optionally) measures OE on-time.
// Optional feature macro: H75_RX_OE_STATS_EN (OE meter built when defined).
module h75_panel_receiver
  import h75_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_ROWS    = h75_pkg::NUM_ROWS,
  parameter int unsigned MAX_COLS    = 512,
  parameter int unsigned OE_CNT_W    = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          pixels_per_row,
  input  logic                clear_err,
  input  logic                led_clk,
  input  logic                latch_enable,
  input  logic                oe,
  input  logic [4:0]          ABCDE,
  input  logic [5:0]          rgb,
  output logic                wr_en,
  output logic [13:0]         wr_addr,
  output logic [5:0]          wr_data,
  output logic                row_latched,
  output logic [4:0]          latched_row,
  output logic [9:0]          col_count,
  output logic                frame_done,
  output logic                oe_valid,
  output logic [4:0]          oe_row,
  output logic [OE_CNT_W-1:0] oe_cycles,
  output logic [2:0]          status_err
);

  localparam int unsigned CW = COL_W + 1;
  localparam logic [CW-1:0] LP_MAX_COLS = CW'(MAX_COLS);
  localparam logic [ROW_W-1:0] LP_LAST_ROW = ROW_W'(NUM_ROWS - 1);

  // Front end
  logic w_clk_lvl, w_clk_rise, w_clk_fall;
  logic w_lat_lvl, w_lat_rise, w_lat_fall;
  logic w_oe_lvl, w_oe_rise, w_oe_fall;

  h75_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_clk (
    .i_clk(clk), .i_reset(reset), .i_d(led_clk),
    .o_level(w_clk_lvl), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
  );

  h75_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_lat (
    .i_clk(clk), .i_reset(reset), .i_d(latch_enable),
    .o_level(w_lat_lvl), .o_rise(w_lat_rise), .o_fall(w_lat_fall)
  );

  h75_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sync_oe (
    .i_clk(clk), .i_reset(reset), .i_d(oe),
    .o_level(w_oe_lvl), .o_rise(w_oe_rise), .o_fall(w_oe_fall)
  );

  logic [5:0]       r_rgb_sync   [SYNC_STAGES];
  logic [ROW_W-1:0] r_abcde_sync [SYNC_STAGES];
  logic [5:0]       w_rgb_s;
  logic [ROW_W-1:0] w_abcde_s;

  // Data buses get the same depth as the controls so they stay aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_rgb_sync[i]   <= '0;
        r_abcde_sync[i] <= '0;
      end
    end else begin
      r_rgb_sync[0]   <= rgb;
      r_abcde_sync[0] <= ABCDE;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_rgb_sync[i]   <= r_rgb_sync[i-1];
        r_abcde_sync[i] <= r_abcde_sync[i-1];
      end
    end
  end

  assign w_rgb_s   = r_rgb_sync[SYNC_STAGES-1];
  assign w_abcde_s = r_abcde_sync[SYNC_STAGES-1];

  // Shift engine / latch state
  logic [0:0]       r_state;
  logic [CW-1:0]    r_col;
  logic [ROW_W-1:0] r_rx_row;
  logic             r_wr_en;
  logic [13:0]      r_wr_addr;
  logic [5:0]       r_wr_data;
  logic             r_row_latched;
  logic [4:0]       r_latched_row;
  logic [9:0]       r_col_count;
  logic             r_frame_done;
  logic [2:0]       r_err;

  logic [CW-1:0]    w_col_cur;
  logic [CW-1:0]    w_col_next;
  logic             w_shift_ok;
  logic             w_row_last;
  logic             w_ovl_set;
  logic [2:0]       w_err_set;

  // Column bookkeeping; w_col_next includes a shift landing in the latch cycle
  always_comb begin
    w_col_cur  = (r_state == S_IDLE) ? '0 : r_col;
    w_shift_ok = w_clk_rise && (w_col_cur < LP_MAX_COLS);
    w_col_next = w_shift_ok ? (w_col_cur + 1'b1) : w_col_cur;
    w_row_last = (r_rx_row == LP_LAST_ROW);
    w_err_set  = '0;
    w_err_set[COL_ERR] = (w_clk_rise && !w_shift_ok) ||
                         (w_lat_rise && (w_col_next != pixels_per_row));
    w_err_set[ROW_ERR] = w_lat_rise && (w_abcde_s != r_rx_row);
    w_err_set[OE_OVL]  = w_ovl_set;
  end

  // Pixel writes, row latch handling and row/frame counting
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_col         <= '0;
      r_rx_row      <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_row_latched <= 1'b0;
      r_latched_row <= '0;
      r_col_count   <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_wr_en       <= w_shift_ok;
      r_row_latched <= w_lat_rise;
      r_frame_done  <= w_lat_rise && w_row_last;
      if (w_shift_ok) begin
        r_wr_addr <= {r_rx_row, w_col_cur[COL_W-1:0]};
        r_wr_data <= w_rgb_s;
      end
      if (w_lat_rise) begin
        r_col_count   <= w_col_next;
        r_latched_row <= w_abcde_s;
        r_col         <= '0;
        r_state       <= S_IDLE;
        r_rx_row      <= w_row_last ? '0 : (r_rx_row + 1'b1);
      end else if (w_shift_ok) begin
        r_col   <= w_col_next;
        r_state <= S_SHIFT;
      end
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= '0;
    end else begin
      r_err <= (clear_err ? 3'b000 : r_err) | w_err_set;
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign row_latched = r_row_latched;
  assign latched_row = r_latched_row;
  assign col_count   = r_col_count;
  assign frame_done  = r_frame_done;
  assign status_err  = r_err;

`ifdef H75_RX_OE_STATS_EN
  logic [0:0]          r_mstate;
  logic [OE_CNT_W-1:0] r_oe_cnt;
  logic [OE_CNT_W-1:0] r_oe_cycles;
  logic                r_oe_valid;
  logic [4:0]          r_oe_row;

  assign w_ovl_set = w_lat_rise && (r_mstate == M_ON);

  // OE on-time meter: counts clk cycles between synchronized oe fall and rise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mstate    <= M_OFF;
      r_oe_cnt    <= '0;
      r_oe_cycles <= '0;
      r_oe_valid  <= 1'b0;
      r_oe_row    <= '0;
    end else begin
      r_oe_valid <= 1'b0;
      if (r_mstate == M_OFF) begin
        if (w_oe_fall) begin
          r_mstate <= M_ON;
          r_oe_cnt <= OE_CNT_W'(1);
        end
      end else begin
        if (w_oe_rise) begin
          r_oe_valid  <= 1'b1;
          r_oe_cycles <= r_oe_cnt;
          r_oe_row    <= r_latched_row;
          r_mstate    <= M_OFF;
        end else if (r_oe_cnt != '1) begin
          r_oe_cnt <= r_oe_cnt + 1'b1;
        end
      end
    end
  end

  assign oe_valid  = r_oe_valid;
  assign oe_row    = r_oe_row;
  assign oe_cycles = r_oe_cycles;

  logic w_unused_lvl;
  assign w_unused_lvl = ^{w_clk_lvl, w_clk_fall, w_lat_lvl, w_lat_fall, w_oe_lvl};
`else
  assign w_ovl_set = 1'b0;
  assign oe_valid  = 1'b0;
  assign oe_row    = '0;
  assign oe_cycles = '0;

  logic w_unused_lvl;
  assign w_unused_lvl = ^{w_clk_lvl, w_clk_fall, w_lat_lvl, w_lat_fall,
                          w_oe_lvl, w_oe_rise, w_oe_fall};
`endif

endmodule
